eth_hdr_insert: RTL and testbench

ETH_HDR_INSERT -- requirements
Module: eth_hdr_insert

---
 rtl/eth_pkg.sv | 23 ++
 rtl/axis_out_reg.sv | 41 ++++
 rtl/eth_hdr_insert.sv | 128 ++++++++++++
 tb/tb_eth_hdr_insert.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared constants, state encoding and header byte selection for the
// Ethernet header inserter.
package eth_pkg;

  localparam int          HDR_LEN        = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DRAIN
  } hdr_state_t;

  // Header is packed {dst_mac, src_mac, ethertype}; byte 0 is the MSB byte.
  function automatic logic [7:0] hdr_byte(input logic [111:0] hdr, input logic [3:0] idx);
    logic [111:0] w_shifted;
    w_shifted = hdr << {idx, 3'b000};
    return w_shifted[111:104];
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXI-Stream output register: 8-bit data plus last, held
// stable while the downstream stalls.
module axis_out_reg (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_ready,
  output logic       o_can_load,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last
);

  logic [7:0] r_data;
  logic       r_valid;
  logic       r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  // A new beat may enter only when the slot is empty or being drained now.
  assign o_can_load = !r_valid || i_ready;
  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_last     = r_last;

endmodule

// File: rtl/eth_hdr_insert.sv
// Prepends a 14-byte Ethernet header (dst, src, ethertype) to each payload
// stream, truncating payloads longer than MAX_PAYLOAD.
module eth_hdr_insert
  import eth_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ethertype,
  output logic [15:0] frame_count,
  output logic [15:0] trunc_count
);

  localparam logic [10:0] MAX_CNT  = 11'(MAX_PAYLOAD);
  localparam logic [3:0]  LAST_HDR = 4'(HDR_LEN - 1);

  hdr_state_t   r_state, w_state_next;
  logic [3:0]   r_hdr_idx, w_hdr_idx_next;
  logic [10:0]  r_pay_cnt, w_pay_cnt_next;
  logic [111:0] r_hdr, w_hdr_next;
  logic [15:0]  r_frame_cnt, w_frame_cnt_next;
  logic [15:0]  r_trunc_cnt, w_trunc_cnt_next;
  logic         w_load, w_load_last, w_can_load, w_s_hs;
  logic [7:0]   w_load_data;

  assign s_tready    = ((r_state == ST_PAYLOAD) && w_can_load) || (r_state == ST_DRAIN);
  assign w_s_hs      = s_tvalid && s_tready;
  assign frame_count = r_frame_cnt;
  assign trunc_count = r_trunc_cnt;

  always_comb begin
    w_state_next     = r_state;
    w_hdr_idx_next   = r_hdr_idx;
    w_pay_cnt_next   = r_pay_cnt;
    w_hdr_next       = r_hdr;
    w_frame_cnt_next = r_frame_cnt;
    w_trunc_cnt_next = r_trunc_cnt;
    w_load           = 1'b0;
    w_load_data      = s_tdata;
    w_load_last      = s_tlast;
    case (r_state)
      ST_IDLE: begin
        if (s_tvalid && w_can_load) begin
          w_hdr_next     = {dst_mac, src_mac, ethertype};
          w_load         = 1'b1;
          w_load_data    = dst_mac[47:40];
          w_load_last    = 1'b0;
          w_hdr_idx_next = 4'd0;
          w_pay_cnt_next = 11'd0;
          w_state_next   = ST_HDR;
        end
      end
      ST_HDR: begin
        // Entering PAYLOAD as byte 13 is loaded lets the first payload byte
        // follow it on the very next accept with no bubble.
        if (m_tvalid && m_tready) begin
          w_hdr_idx_next = r_hdr_idx + 4'd1;
          w_load         = 1'b1;
          w_load_data    = hdr_byte(r_hdr, w_hdr_idx_next);
          w_load_last    = 1'b0;
          if (w_hdr_idx_next == LAST_HDR) w_state_next = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (w_s_hs) begin
          w_load         = 1'b1;
          w_pay_cnt_next = r_pay_cnt + 11'd1;
          if (s_tlast) begin
            w_frame_cnt_next = r_frame_cnt + 16'd1;
            w_state_next     = ST_IDLE;
          end else if (w_pay_cnt_next == MAX_CNT) begin
            w_load_last      = 1'b1;
            w_frame_cnt_next = r_frame_cnt + 16'd1;
            if (r_trunc_cnt != 16'hFFFF) w_trunc_cnt_next = r_trunc_cnt + 16'd1;
            w_state_next     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (s_tvalid && s_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_hdr_idx   <= 4'd0;
      r_pay_cnt   <= 11'd0;
      r_hdr       <= '0;
      r_frame_cnt <= 16'd0;
      r_trunc_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_next;
      r_hdr_idx   <= w_hdr_idx_next;
      r_pay_cnt   <= w_pay_cnt_next;
      r_hdr       <= w_hdr_next;
      r_frame_cnt <= w_frame_cnt_next;
      r_trunc_cnt <= w_trunc_cnt_next;
    end
  end

  axis_out_reg u_out_reg (
    .i_clk      (aclk),
    .i_rst_n    (aresetn),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_last     (w_load_last),
    .i_ready    (m_tready),
    .o_can_load (w_can_load),
    .o_data     (m_tdata),
    .o_valid    (m_tvalid),
    .o_last     (m_tlast)
  );

endmodule

// File: tb/tb_eth_hdr_insert.sv
// Self-checking bench for eth_hdr_insert: directed scenarios plus randomized
// frames compared against a queue-based frame model.
module tb_eth_hdr_insert;
  import eth_pkg::*;

  localparam int MAXP = 1500;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [47:0] dst_mac = '0;
  logic [47:0] src_mac = '0;
  logic [15:0] ethertype = '0;
  logic [15:0] frame_count;
  logic [15:0] trunc_count;

  eth_hdr_insert #(.MAX_PAYLOAD(MAXP)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tready    (m_tready),
    .dst_mac     (dst_mac),
    .src_mac     (src_mac),
    .ethertype   (ethertype),
    .frame_count (frame_count),
    .trunc_count (trunc_count)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] in_q[$];
  logic [8:0] exp_q[$];
  int exp_frames = 0;
  int exp_trunc  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame model: header from the fields present when the frame is queued,
  // followed by at most MAXP payload bytes, last flag on the final beat.
  task automatic add_frame(input int n, input bit fixed);
    logic [111:0] h;
    logic [7:0]   b;
    int keep;
    h    = {dst_mac, src_mac, ethertype};
    keep = (n > MAXP) ? MAXP : n;
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, h[111 - 8*i -: 8]});
    for (int i = 0; i < n; i++) begin
      b = fixed ? 8'(i + 1) : 8'($urandom);
      in_q.push_back({(i == n - 1), b});
      if (i < keep) exp_q.push_back({(i == keep - 1), b});
    end
    exp_frames++;
    if (n > MAXP) exp_trunc++;
  endtask

  task automatic run(input int rmode, input int vmode, input int chg_beat,
                     input logic [47:0] new_dst, input int abort_at, input bit tp);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = 0;
    int budget;
    bit s_acc = 1'b0;
    bit prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;
    budget = 8 * (in_q.size() + exp_q.size()) + 100;
    while ((got < exp_q.size() || idx < in_q.size()) && cyc < budget) begin
      @(negedge aclk);
      if (s_acc) begin
        idx++;
        s_tvalid = 1'b0;
      end
      if (idx < in_q.size()) begin
        if (!s_tvalid) s_tvalid = (vmode == 0) || ($urandom_range(3) != 0);
        {s_tlast, s_tdata} = in_q[idx];
      end else begin
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
      end
      case (rmode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(1));
      endcase
      #1;
      if (prev_stall) chk("hold", {m_tvalid, m_tlast, m_tdata}, prev_beat);
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tvalid, m_tlast, m_tdata};
      s_acc      = s_tvalid && s_tready;
      if (m_tvalid && m_tready) begin
        if (got < exp_q.size()) chk($sformatf("beat%0d", got), {m_tlast, m_tdata}, exp_q[got]);
        else chk("extra_beat_tvalid", m_tvalid, 0);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
        if (got == chg_beat) dst_mac = new_dst;
        if (got == abort_at) begin
          aresetn = 1'b0;
          #1;
          chk("rst_tvalid", m_tvalid, 0);
          chk("rst_tlast", m_tlast, 0);
          chk("rst_tdata", m_tdata, 0);
          chk("rst_tready", s_tready, 0);
          chk("rst_frame_count", frame_count, 0);
          chk("rst_trunc_count", trunc_count, 0);
          s_tvalid   = 1'b0;
          exp_frames = 0;
          exp_trunc  = 0;
          in_q.delete();
          exp_q.delete();
          @(negedge aclk);
          aresetn = 1'b1;
          return;
        end
      end
      cyc++;
    end
    chk("out_beats", got, exp_q.size());
    chk("in_beats", idx, in_q.size());
    if (tp) chk("throughput_cycles", last_cyc - first_cyc + 1, exp_q.size());
    in_q.delete();
    exp_q.delete();
  endtask

  task automatic check_counts();
    @(negedge aclk);
    #1;
    chk("idle_tvalid", m_tvalid, 0);
    chk("frame_count", frame_count, 16'(exp_frames));
    chk("trunc_count", trunc_count, 16'(exp_trunc));
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_tvalid", m_tvalid, 0);
    chk("reset_tlast", m_tlast, 0);
    chk("reset_tdata", m_tdata, 0);
    chk("reset_tready", s_tready, 0);
    chk("reset_frame_count", frame_count, 0);
    chk("reset_trunc_count", trunc_count, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Reference frame, continuous ready
    dst_mac   = 48'hFFFF_FFFF_FFFF;
    src_mac   = 48'h000A_3501_0203;
    ethertype = ETHERTYPE_IPV4;
    add_frame(4, 1'b1);
    run(0, 0, -1, '0, -1, 1'b1);
    check_counts();

    // Same frame, ready toggling
    add_frame(4, 1'b1);
    run(1, 0, -1, '0, -1, 1'b0);
    check_counts();

    // Truncation: 1600 bytes in, 1514 beats out
    add_frame(1600, 1'b0);
    run(0, 0, -1, '0, -1, 1'b0);
    check_counts();

    // Back-to-back single-byte frames
    add_frame(1, 1'b0);
    add_frame(1, 1'b0);
    run(0, 0, -1, '0, -1, 1'b1);
    check_counts();

    // Header fields change mid-frame
    dst_mac   = {16'($urandom), 32'($urandom)};
    src_mac   = {16'($urandom), 32'($urandom)};
    ethertype = ETHERTYPE_ARP;
    add_frame(20, 1'b0);
    run(2, 1, 3, {16'($urandom), 32'($urandom)}, -1, 1'b0);
    add_frame(10, 1'b0);
    run(0, 0, -1, '0, -1, 1'b1);
    check_counts();

    // Payload length boundaries
    add_frame(MAXP, 1'b0);
    add_frame(MAXP + 1, 1'b0);
    run(2, 0, -1, '0, -1, 1'b0);
    check_counts();

    // Randomized frames and handshakes
    for (int f = 0; f < 6; f++) begin
      dst_mac   = {16'($urandom), 32'($urandom)};
      src_mac   = {16'($urandom), 32'($urandom)};
      ethertype = ($urandom_range(1) != 0) ? ETHERTYPE_IPV4 : 16'($urandom);
      add_frame($urandom_range(1, 60), 1'b0);
      add_frame($urandom_range(1, 60), 1'b0);
      run($urandom_range(2), $urandom_range(1), -1, '0, -1, 1'b0);
      check_counts();
    end

    // Reset during payload, then a clean frame
    add_frame(40, 1'b0);
    run(0, 0, -1, '0, 25, 1'b0);
    repeat (3) begin
      @(negedge aclk);
      #1;
      chk("post_reset_tvalid", m_tvalid, 0);
    end
    dst_mac = {16'($urandom), 32'($urandom)};
    add_frame(8, 1'b0);
    run(0, 0, -1, '0, -1, 1'b1);
    check_counts();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
